// File: rtl/wt_cache_pkg.sv
// Shared icache refill types and default geometry for the AXI R-channel line assembler.
package wt_cache_pkg;

    localparam int unsigned ICACHE_LINE_WIDTH   = 128;
    localparam int unsigned ICACHE_BEAT_WIDTH   = 64;
    localparam int unsigned ICACHE_ID_WIDTH     = 4;
    localparam int unsigned ICACHE_REFILL_DEPTH = 2;
    localparam int unsigned ICACHE_REFILL_BEATS = ICACHE_LINE_WIDTH / 64;

    typedef struct packed {
        logic [ICACHE_LINE_WIDTH-1:0] data;
        logic [ICACHE_ID_WIDTH-1:0]   id;
        logic                         err;
    } icache_refill_line_t;

    // Index width that stays legal (>= 1 bit) even for single-entry structures.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/icache_refill_ring.sv
// Depth-entry ring of refill lines: the tail entry is assembled in place, the head entry is
// presented to the icache.
module icache_refill_ring
    import wt_cache_pkg::*;
#(
    parameter int unsigned LineWidth = ICACHE_LINE_WIDTH,
    parameter int unsigned BeatWidth = ICACHE_BEAT_WIDTH,
    parameter int unsigned IdWidth   = ICACHE_ID_WIDTH,
    parameter int unsigned Depth     = ICACHE_REFILL_DEPTH,
    parameter int unsigned SlotWidth = idx_width(LineWidth / BeatWidth),
    parameter int unsigned CntWidth  = $clog2(Depth + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 wr_en_i,
    input  logic                 wr_first_i,
    input  logic                 wr_store_i,
    input  logic [SlotWidth-1:0] wr_slot_i,
    input  logic [BeatWidth-1:0] wr_data_i,
    input  logic [IdWidth-1:0]   wr_id_i,
    input  logic                 wr_err_i,
    input  logic                 commit_i,
    input  logic                 pop_i,
    output logic [IdWidth-1:0]   wr_id_o,
    output logic [LineWidth-1:0] rd_data_o,
    output logic [IdWidth-1:0]   rd_id_o,
    output logic                 rd_err_o,
    output logic [CntWidth-1:0]  count_o,
    output logic                 full_o
);

    localparam int unsigned PtrWidth = idx_width(Depth);
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Depth - 1);
    localparam logic [CntWidth-1:0] DepthCnt = CntWidth'(Depth);

    typedef struct packed {
        logic [LineWidth-1:0] data;
        logic [IdWidth-1:0]   id;
        logic                 err;
    } entry_t;

    entry_t                mem_q [Depth];
    entry_t                wr_entry;
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [CntWidth-1:0]   count_q;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + 1'b1;
    endfunction

    // NOTE: wr_entry is fully assigned from mem_q before any conditional update, so no latch.
    always_comb begin
        wr_entry = mem_q[wr_ptr_q];
        if (wr_first_i) begin
            wr_entry.data = '0;
            wr_entry.id   = wr_id_i;
            wr_entry.err  = 1'b0;
        end
        if (wr_store_i) begin
            wr_entry.data[wr_slot_i*BeatWidth +: BeatWidth] = wr_data_i;
        end
        wr_entry.err = wr_entry.err | wr_err_i;
    end

    // NOTE: the entries are reset too, so the head line reads as zeros rather than X out of reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) begin
                mem_q[wr_ptr_q] <= wr_entry;
            end
            if (commit_i) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({commit_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign wr_id_o   = mem_q[wr_ptr_q].id;
    assign rd_data_o = mem_q[rd_ptr_q].data;
    assign rd_id_o   = mem_q[rd_ptr_q].id;
    assign rd_err_o  = mem_q[rd_ptr_q].err;
    assign count_o   = count_q;
    assign full_o    = (count_q == DepthCnt);

endmodule

// File: rtl/icache_refill_assembler.sv
// Assembles AXI R beats into icache refill lines; tracks beat position, flush discard and handshakes.
module icache_refill_assembler
    import wt_cache_pkg::*;
#(
    parameter int unsigned LineWidth = ICACHE_LINE_WIDTH,
    parameter int unsigned BeatWidth = ICACHE_BEAT_WIDTH,
    parameter int unsigned IdWidth   = ICACHE_ID_WIDTH,
    parameter int unsigned Depth     = ICACHE_REFILL_DEPTH
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 r_valid_i,
    output logic                 r_ready_o,
    input  logic [BeatWidth-1:0] r_data_i,
    input  logic                 r_last_i,
    input  logic [IdWidth-1:0]   r_id_i,
    input  logic [1:0]           r_resp_i,
    output logic                 line_valid_o,
    input  logic                 line_ready_i,
    output logic [LineWidth-1:0] line_data_o,
    output logic [IdWidth-1:0]   line_id_o,
    output logic                 line_err_o,
    output logic                 busy_o
);

    localparam int unsigned NumBeats  = LineWidth / BeatWidth;
    localparam int unsigned SlotWidth = idx_width(NumBeats);
    localparam int unsigned CntWidth  = $clog2(Depth + 1);
    localparam int unsigned BcWidth   = $clog2(NumBeats + 1);
    localparam logic [BcWidth-1:0] BeatsMax = BcWidth'(NumBeats);

    logic [BcWidth-1:0]  beat_cnt_q;
    logic                discard_q;
    logic [CntWidth-1:0] count;
    logic                full;
    logic [IdWidth-1:0]  latched_id;
    logic                accept;
    logic                first;
    logic                overlong;
    logic                wr_en;
    logic                wr_err;
    logic                commit;
    logic                pop;

    assign r_ready_o    = ~full;
    assign line_valid_o = (count != '0);
    assign busy_o       = line_valid_o | (beat_cnt_q != '0) | discard_q;

    assign accept   = r_valid_i & r_ready_o;
    assign first    = (beat_cnt_q == '0);
    assign overlong = (beat_cnt_q == BeatsMax);
    // A beat landing in a flush cycle belongs to a burst that is being thrown away.
    assign wr_en    = accept & ~discard_q & ~flush_i;
    assign commit   = wr_en & r_last_i;
    assign pop      = line_valid_o & line_ready_i & ~flush_i;
    assign wr_err   = r_resp_i[1] | overlong | (~first & (r_id_i != latched_id));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            beat_cnt_q <= '0;
            discard_q  <= 1'b0;
        end else if (flush_i) begin
            beat_cnt_q <= '0;
            discard_q  <= accept ? ~r_last_i : (discard_q | (beat_cnt_q != '0));
        end else if (accept) begin
            if (r_last_i) begin
                beat_cnt_q <= '0;
                discard_q  <= 1'b0;
            end else if (!discard_q && !overlong) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

    icache_refill_ring #(
        .LineWidth (LineWidth),
        .BeatWidth (BeatWidth),
        .IdWidth   (IdWidth),
        .Depth     (Depth),
        .SlotWidth (SlotWidth),
        .CntWidth  (CntWidth)
    ) u_ring (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (flush_i),
        .wr_en_i    (wr_en),
        .wr_first_i (first),
        .wr_store_i (~overlong),
        .wr_slot_i  (beat_cnt_q[SlotWidth-1:0]),
        .wr_data_i  (r_data_i),
        .wr_id_i    (r_id_i),
        .wr_err_i   (wr_err),
        .commit_i   (commit),
        .pop_i      (pop),
        .wr_id_o    (latched_id),
        .rd_data_o  (line_data_o),
        .rd_id_o    (line_id_o),
        .rd_err_o   (line_err_o),
        .count_o    (count),
        .full_o     (full)
    );

endmodule

// File: tb/tb_icache_refill_assembler.sv
// Self-checking bench: directed vector table, hand-written corner sequences and a random run
// against a queue-based line model.
module tb_icache_refill_assembler;
    import wt_cache_pkg::*;

    localparam int LW    = 128;
    localparam int BW    = 64;
    localparam int IW    = 4;
    localparam int DEPTH = 2;
    localparam int NB    = LW / BW;

    localparam logic [63:0] PA = 64'hAAAA_AAAA_AAAA_AAAA;
    localparam logic [63:0] PB = 64'hBBBB_BBBB_BBBB_BBBB;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          r_valid_i = 1'b0;
    logic          r_ready_o;
    logic [BW-1:0] r_data_i = '0;
    logic          r_last_i = 1'b0;
    logic [IW-1:0] r_id_i = '0;
    logic [1:0]    r_resp_i = '0;
    logic          line_valid_o;
    logic          line_ready_i = 1'b0;
    logic [LW-1:0] line_data_o;
    logic [IW-1:0] line_id_o;
    logic          line_err_o;
    logic          busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    icache_refill_assembler #(
        .LineWidth (LW),
        .BeatWidth (BW),
        .IdWidth   (IW),
        .Depth     (DEPTH)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .flush_i      (flush_i),
        .r_valid_i    (r_valid_i),
        .r_ready_o    (r_ready_o),
        .r_data_i     (r_data_i),
        .r_last_i     (r_last_i),
        .r_id_i       (r_id_i),
        .r_resp_i     (r_resp_i),
        .line_valid_o (line_valid_o),
        .line_ready_i (line_ready_i),
        .line_data_o  (line_data_o),
        .line_id_o    (line_id_o),
        .line_err_o   (line_err_o),
        .busy_o       (busy_o)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Drive one beat and hold it until the handshake edge, bounded by a cycle budget.
    task automatic send_beat(input logic [63:0] d, input logic last, input logic [3:0] id,
                             input logic [1:0] resp);
        logic hs;
        hs = 1'b0;
        r_valid_i = 1'b1;
        r_data_i  = d;
        r_last_i  = last;
        r_id_i    = id;
        r_resp_i  = resp;
        for (int i = 0; i < 50; i++) begin
            hs = r_ready_o;
            tick();
            if (hs) break;
        end
        check("beat_handshake", 128'(hs), 128'(1'b1));
        r_valid_i = 1'b0;
        r_last_i  = 1'b0;
    endtask

    task automatic pop_line();
        line_ready_i = 1'b1;
        tick();
        line_ready_i = 1'b0;
    endtask

    task automatic check_line(input string name, input logic [3:0] id, input logic [127:0] data,
                              input logic err);
        check({name, "_valid"}, 128'(line_valid_o), 128'(1'b1));
        check({name, "_id"}, 128'(line_id_o), 128'(id));
        check({name, "_data"}, line_data_o, data);
        check({name, "_err"}, 128'(line_err_o), 128'(err));
    endtask

    // Directed vectors: inputs for one cycle, expected outputs just after that cycle's edge.
    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        last;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        lr;
        logic        ev;
        logic [127:0] ed;
        logic [3:0]  eid;
        logic        ee;
        logic        ebusy;
        logic        erdy;
    } vec_t;

    vec_t vecs [19];

    // Behavioural model: a queue of completed lines plus the line being assembled.
    icache_refill_line_t exp_q[$];
    icache_refill_line_t m_line;
    int                  m_n;
    bit                  m_disc;

    task automatic model_reset();
        exp_q.delete();
        m_line = '0;
        m_n    = 0;
        m_disc = 0;
    endtask

    task automatic model_step();
        bit acc;
        bit pop;
        acc = r_valid_i && (exp_q.size() < DEPTH);
        pop = (exp_q.size() != 0) && line_ready_i && !flush_i;
        if (flush_i) begin
            exp_q.delete();
            m_disc = acc ? !r_last_i : (m_disc || (m_n != 0));
            m_n = 0;
        end else begin
            if (pop) void'(exp_q.pop_front());
            if (acc) begin
                if (m_disc) begin
                    if (r_last_i) m_disc = 0;
                end else begin
                    if (m_n == 0) begin
                        m_line     = '0;
                        m_line.id  = r_id_i;
                        m_line.err = r_resp_i[1];
                    end else if (r_id_i != m_line.id || r_resp_i[1]) begin
                        m_line.err = 1'b1;
                    end
                    if (m_n < NB) m_line.data[m_n*64 +: 64] = r_data_i;
                    else m_line.err = 1'b1;
                    m_n++;
                    if (r_last_i) begin
                        exp_q.push_back(m_line);
                        m_n = 0;
                    end
                end
            end
        end
    endtask

    initial begin
        logic [3:0] bid;
        // Reset values, sampled while reset is held.
        #12;
        check("rst_ready", 128'(r_ready_o), 128'(1'b1));
        check("rst_valid", 128'(line_valid_o), 128'(1'b0));
        check("rst_data", line_data_o, 128'(0));
        check("rst_id", 128'(line_id_o), 128'(0));
        check("rst_err", 128'(line_err_o), 128'(1'b0));
        check("rst_busy", 128'(busy_o), 128'(1'b0));
        #10 rst_ni = 1'b1;
        tick();

        //        v     d                   last  id     resp   lr    ev    ed                                  eid    ee    busy  rdy
        vecs[0]  = '{1'b1, PA,               1'b0, 4'd3, 2'b00, 1'b0, 1'b0, 128'd0,                             4'd0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{1'b1, PB,               1'b1, 4'd3, 2'b00, 1'b0, 1'b1, {PB, PA},                           4'd3, 1'b0, 1'b1, 1'b1};
        vecs[2]  = '{1'b0, 64'd0,            1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 128'd0,                             4'd0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 64'h1234,         1'b1, 4'd5, 2'b00, 1'b0, 1'b1, {64'd0, 64'h1234},                  4'd5, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 64'd0,            1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 128'd0,                             4'd0, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{1'b1, 64'h1,            1'b0, 4'd2, 2'b00, 1'b0, 1'b0, 128'd0,                             4'd0, 1'b0, 1'b1, 1'b1};
        vecs[6]  = '{1'b1, 64'h2,            1'b1, 4'd2, 2'b10, 1'b0, 1'b1, {64'h2, 64'h1},                     4'd2, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{1'b0, 64'd0,            1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 128'd0,                             4'd0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 64'h11,           1'b0, 4'd1, 2'b00, 1'b0, 1'b0, 128'd0,                             4'd0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{1'b1, 64'h22,           1'b0, 4'd1, 2'b00, 1'b0, 1'b0, 128'd0,                             4'd0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1'b1, 64'h33,           1'b1, 4'd1, 2'b00, 1'b0, 1'b1, {64'h22, 64'h11},                   4'd1, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{1'b0, 64'd0,            1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 128'd0,                             4'd0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 64'h5,            1'b0, 4'd4, 2'b00, 1'b0, 1'b0, 128'd0,                             4'd0, 1'b0, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 64'h6,            1'b1, 4'd6, 2'b00, 1'b0, 1'b1, {64'h6, 64'h5},                     4'd4, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{1'b0, 64'd0,            1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 128'd0,                             4'd0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 64'h7,            1'b1, 4'd7, 2'b00, 1'b0, 1'b1, {64'd0, 64'h7},                     4'd7, 1'b0, 1'b1, 1'b1};
        vecs[16] = '{1'b1, 64'h8,            1'b0, 4'd8, 2'b00, 1'b0, 1'b1, {64'd0, 64'h7},                     4'd7, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 64'h9,            1'b1, 4'd8, 2'b00, 1'b1, 1'b1, {64'h9, 64'h8},                     4'd8, 1'b0, 1'b1, 1'b1};
        vecs[18] = '{1'b0, 64'd0,            1'b0, 4'd0, 2'b00, 1'b1, 1'b0, 128'd0,                             4'd0, 1'b0, 1'b0, 1'b1};

        foreach (vecs[i]) begin
            r_valid_i    = vecs[i].v;
            r_data_i     = vecs[i].d;
            r_last_i     = vecs[i].last;
            r_id_i       = vecs[i].id;
            r_resp_i     = vecs[i].resp;
            line_ready_i = vecs[i].lr;
            tick();
            check($sformatf("vec%0d_ready", i), 128'(r_ready_o), 128'(vecs[i].erdy));
            check($sformatf("vec%0d_valid", i), 128'(line_valid_o), 128'(vecs[i].ev));
            check($sformatf("vec%0d_busy", i), 128'(busy_o), 128'(vecs[i].ebusy));
            if (vecs[i].ev) begin
                check($sformatf("vec%0d_data", i), line_data_o, vecs[i].ed);
                check($sformatf("vec%0d_id", i), 128'(line_id_o), 128'(vecs[i].eid));
                check($sformatf("vec%0d_err", i), 128'(line_err_o), 128'(vecs[i].ee));
            end
        end
        r_valid_i    = 1'b0;
        r_last_i     = 1'b0;
        line_ready_i = 1'b0;

        // Backpressure: two lines fill the ring, the third burst stalls until one pop.
        send_beat(64'h100, 1'b0, 4'd0, 2'b00);
        send_beat(64'h101, 1'b1, 4'd0, 2'b00);
        send_beat(64'h110, 1'b0, 4'd1, 2'b00);
        send_beat(64'h111, 1'b1, 4'd1, 2'b00);
        check("bp_full_ready", 128'(r_ready_o), 128'(1'b0));
        check_line("bp_line0", 4'd0, {64'h101, 64'h100}, 1'b0);
        r_valid_i = 1'b1;
        r_data_i  = 64'h120;
        r_last_i  = 1'b0;
        r_id_i    = 4'd2;
        r_resp_i  = 2'b00;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_stall_ready", 128'(r_ready_o), 128'(1'b0));
        end
        pop_line();
        check("bp_reready", 128'(r_ready_o), 128'(1'b1));
        check_line("bp_line1", 4'd1, {64'h111, 64'h110}, 1'b0);
        send_beat(64'h120, 1'b0, 4'd2, 2'b00);
        send_beat(64'h121, 1'b1, 4'd2, 2'b00);
        check_line("bp_line1_hold", 4'd1, {64'h111, 64'h110}, 1'b0);
        pop_line();
        check_line("bp_line2", 4'd2, {64'h121, 64'h120}, 1'b0);
        pop_line();
        check("bp_empty", 128'(line_valid_o), 128'(1'b0));

        // Flush mid-burst with one line buffered.
        send_beat(PA, 1'b0, 4'd9, 2'b00);
        send_beat(PB, 1'b1, 4'd9, 2'b00);
        send_beat(64'hC, 1'b0, 4'd10, 2'b00);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        check("fl_valid", 128'(line_valid_o), 128'(1'b0));
        check("fl_busy_discard", 128'(busy_o), 128'(1'b1));
        send_beat(64'hD, 1'b1, 4'd10, 2'b00);
        check("fl_busy_after", 128'(busy_o), 128'(1'b0));
        check("fl_valid_after", 128'(line_valid_o), 128'(1'b0));
        send_beat(64'hE, 1'b0, 4'd11, 2'b00);
        send_beat(64'hF, 1'b1, 4'd11, 2'b00);
        check_line("fl_next", 4'd11, {64'hF, 64'hE}, 1'b0);
        pop_line();

        // Reset in the middle of a burst clears everything.
        send_beat(64'h77, 1'b0, 4'd3, 2'b00);
        #2 rst_ni = 1'b0;
        #1;
        check("mrst_busy", 128'(busy_o), 128'(1'b0));
        check("mrst_ready", 128'(r_ready_o), 128'(1'b1));
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        model_reset();

        // Random traffic against the model.
        bid = 4'($urandom_range(0, 15));
        for (int c = 0; c < 1500; c++) begin
            r_valid_i    = ($urandom_range(0, 9) < 7);
            r_data_i     = {$urandom, $urandom};
            r_last_i     = ($urandom_range(0, 9) < 4);
            r_id_i       = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(0, 15)) : bid;
            r_resp_i     = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
            line_ready_i = ($urandom_range(0, 1) == 1);
            flush_i      = ($urandom_range(0, 39) == 0);
            if (r_last_i) bid = 4'($urandom_range(0, 15));
            model_step();
            tick();
            check("rnd_ready", 128'(r_ready_o), 128'(exp_q.size() < DEPTH));
            check("rnd_valid", 128'(line_valid_o), 128'(exp_q.size() != 0));
            check("rnd_busy", 128'(busy_o), 128'((exp_q.size() != 0) || (m_n != 0) || m_disc));
            if (exp_q.size() != 0) begin
                check("rnd_data", line_data_o, exp_q[0].data);
                check("rnd_id", 128'(line_id_o), 128'(exp_q[0].id));
                check("rnd_err", 128'(line_err_o), 128'(exp_q[0].err));
            end
        end
        r_valid_i    = 1'b0;
        flush_i      = 1'b0;
        line_ready_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
